rect_fill_engine: RTL and testbench

Hardware rectangle-fill stage that sits upstream of MemoryManager's MPU write port, alongside MCUInterface. It takes a rectangle (origin, size, colour), clips it to the 320x240 framebuffer, and issues one pixel write per framebuffer location in raster order. It uses the memoryWrite request/complete handshake, so the MPU can clear or fill regions without per-pixel register traffic.

---
 rtl/rect_fill_pkg.sv | 23 ++
 rtl/rect_fill_if.sv | 21 ++
 rtl/rect_clip.sv | 31 +++
 rtl/rect_fill_engine.sv | 145 ++++++++++++++
 tb/tb_rect_fill_engine.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rect_fill_pkg.sv
// Shared types and constants for the rectangle-fill engine.
package rect_fill_pkg;

    localparam int SCREEN_W_DEF = 320;
    localparam int SCREEN_H_DEF = 240;
    localparam int X_W    = 9;
    localparam int Y_W    = 8;
    localparam int PIX_W  = 8;
    // One bit wider than X_W so x+width can never wrap
    localparam int CLIP_W = 10;

    typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, FINISH} state_e;

    // Operands latched on start
    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [X_W-1:0]   w;
        logic [Y_W-1:0]   h;
        logic [PIX_W-1:0] color;
    } rect_t;

endpackage

// File: rtl/rect_fill_if.sv
// Pixel-write bus between the fill engine (master) and MemoryManager (slave).
interface rect_fill_if;
    import rect_fill_pkg::*;

    logic [X_W-1:0]   memoryXCoord;
    logic [Y_W-1:0]   memoryYCoord;
    logic [PIX_W-1:0] memoryWriteData;
    logic             memoryWriteRequest;
    logic             memoryWriteComplete;

    modport master (
        output memoryXCoord, memoryYCoord, memoryWriteData, memoryWriteRequest,
        input  memoryWriteComplete
    );

    modport slave (
        input  memoryXCoord, memoryYCoord, memoryWriteData, memoryWriteRequest,
        output memoryWriteComplete
    );

endinterface

// File: rtl/rect_clip.sv
// Combinational clip of a rectangle against the screen: exclusive end
// coordinates and an "empty" flag when nothing is visible.
module rect_clip
    import rect_fill_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  rect_t             rect_i,
    output logic [CLIP_W-1:0] x_end_o,
    output logic [CLIP_W-1:0] y_end_o,
    output logic              empty_o
);

    localparam logic [CLIP_W-1:0] SW = CLIP_W'(SCREEN_W);
    localparam logic [CLIP_W-1:0] SH = CLIP_W'(SCREEN_H);

    logic [CLIP_W-1:0] x_sum, y_sum, x0, y0;

    // min(origin+size, screen) in 10-bit arithmetic
    always_comb begin
        x0      = {1'b0, rect_i.x};
        y0      = {2'b0, rect_i.y};
        x_sum   = x0 + {1'b0, rect_i.w};
        y_sum   = y0 + {2'b0, rect_i.h};
        x_end_o = (x_sum > SW) ? SW : x_sum;
        y_end_o = (y_sum > SH) ? SH : y_sum;
        empty_o = (x0 >= SW) || (y0 >= SH) || (rect_i.w == '0) || (rect_i.h == '0);
    end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill: clips a rectangle to the framebuffer and issues one
// request/complete pixel write per visible location in raster order.
// Optional checkerboard second colour: define RECT_FILL_PATTERN_EN.
module rect_fill_engine
    import rect_fill_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [X_W-1:0]   rectX,
    input  logic [Y_W-1:0]   rectY,
    input  logic [X_W-1:0]   rectWidth,
    input  logic [Y_W-1:0]   rectHeight,
    input  logic [PIX_W-1:0] fillColor,
`ifdef RECT_FILL_PATTERN_EN
    input  logic [PIX_W-1:0] fillColorAlt,
`endif
    output logic             busy,
    output logic             done,
    rect_fill_if.master      mem
);

    state_e            state_q;
    rect_t             rect_q;
    logic [X_W-1:0]    x_q, mx_q;
    logic [Y_W-1:0]    y_q, my_q;
    logic [PIX_W-1:0]  md_q;
    logic [CLIP_W-1:0] x_end_q, y_end_q;
    logic              busy_q, done_q, req_q;
`ifdef RECT_FILL_PATTERN_EN
    logic [PIX_W-1:0]  alt_q;
`endif

    logic [CLIP_W-1:0] clip_x_end, clip_y_end;
    logic              clip_empty;

    rect_clip #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_clip (
        .rect_i  (rect_q),
        .x_end_o (clip_x_end),
        .y_end_o (clip_y_end),
        .empty_o (clip_empty)
    );

    logic [CLIP_W-1:0] x_inc, y_inc;
    logic [X_W-1:0]    x_d;
    logic [Y_W-1:0]    y_d;
    logic              row_end, last_d;
    logic [PIX_W-1:0]  pix_d;

    // Next raster position after the current pixel, and its colour
    always_comb begin
        x_inc   = {1'b0, x_q} + CLIP_W'(1);
        y_inc   = {2'b0, y_q} + CLIP_W'(1);
        row_end = (x_inc == x_end_q);
        x_d     = x_inc[X_W-1:0];
        y_d     = y_q;
        if (row_end) begin
            x_d = rect_q.x;
            y_d = y_inc[Y_W-1:0];
        end
        last_d = row_end && (y_inc == y_end_q);
`ifdef RECT_FILL_PATTERN_EN
        pix_d = (x_q[0] ^ y_q[0]) ? alt_q : rect_q.color;
`else
        pix_d = rect_q.color;
`endif
    end

    // Control FSM with registered bus and status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rect_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            md_q    <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef RECT_FILL_PATTERN_EN
            alt_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= start;
                    if (start) begin
                        rect_q  <= '{x: rectX, y: rectY, w: rectWidth,
                                     h: rectHeight, color: fillColor};
`ifdef RECT_FILL_PATTERN_EN
                        alt_q   <= fillColorAlt;
`endif
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    x_end_q <= clip_x_end;
                    y_end_q <= clip_y_end;
                    x_q     <= rect_q.x;
                    y_q     <= rect_q.y;
                    state_q <= (clip_empty || abort) ? FINISH : ISSUE;
                end
                ISSUE: begin
                    mx_q    <= x_q;
                    my_q    <= y_q;
                    md_q    <= pix_d;
                    req_q   <= 1'b1;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // abort is only honoured once the in-flight write completes
                    if (mem.memoryWriteComplete) begin
                        req_q   <= 1'b0;
                        x_q     <= x_d;
                        y_q     <= y_d;
                        state_q <= (last_d || abort) ? FINISH : ISSUE;
                    end
                end
                FINISH: begin
                    // busy stays high through the done cycle, drops in IDLE
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy                   = busy_q;
    assign done                   = done_q;
    assign mem.memoryXCoord       = mx_q;
    assign mem.memoryYCoord       = my_q;
    assign mem.memoryWriteData    = md_q;
    assign mem.memoryWriteRequest = req_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Scoreboard bench for rect_fill_engine: expected pixel writes are queued
// when a fill is launched and popped as the memory model sees requests.
module tb_rect_fill_engine;
    import rect_fill_pkg::*;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [X_W-1:0]   rectX = '0;
    logic [Y_W-1:0]   rectY = '0;
    logic [X_W-1:0]   rectWidth = '0;
    logic [Y_W-1:0]   rectHeight = '0;
    logic [PIX_W-1:0] fillColor = '0;
    logic [PIX_W-1:0] fillColorAlt = '0;
    logic             busy, done;

    rect_fill_if mem();

    rect_fill_engine dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .rectX      (rectX),
        .rectY      (rectY),
        .rectWidth  (rectWidth),
        .rectHeight (rectHeight),
        .fillColor  (fillColor),
`ifdef RECT_FILL_PATTERN_EN
        .fillColorAlt (fillColorAlt),
`endif
        .busy       (busy),
        .done       (done),
        .mem        (mem)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    endtask

    // Expected writes {x, y, data}
    logic [24:0] sb[$];

    int  cyc = 0, start_cyc = 0, done_cyc = 0, first_req_cyc = 0;
    int  done_cnt = 0, wr_cnt = 0, ack_delay = 0, wait_cnt = 0;
    bit  in_req = 0, first_pend = 0, spur = 0;
    logic [24:0] cap;

    // Memory model / monitor: samples 1 time unit after each rising edge
    initial begin
        mem.memoryWriteComplete = 1'b0;
        forever begin
            @(posedge clock); #1;
            cyc++;
            if (start) start_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", 32'(busy), 32'd1);
            end
            if (mem.memoryWriteRequest) begin
                if (!in_req) begin
                    in_req = 1;
                    wr_cnt++;
                    wait_cnt = 0;
                    if (first_pend) begin first_req_cyc = cyc; first_pend = 0; end
                    cap = {mem.memoryXCoord, mem.memoryYCoord, mem.memoryWriteData};
                    chk("x_in_screen", 32'(mem.memoryXCoord < 9'd320), 32'd1);
                    chk("y_in_screen", 32'(mem.memoryYCoord < 8'd240), 32'd1);
                    chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) chk("write", 32'(cap), 32'(sb.pop_front()));
                end else begin
                    chk("held_stable", 32'({mem.memoryXCoord, mem.memoryYCoord,
                                            mem.memoryWriteData}), 32'(cap));
                end
                if (wait_cnt >= ack_delay) mem.memoryWriteComplete = 1'b1;
                else begin mem.memoryWriteComplete = 1'b0; wait_cnt++; end
            end else begin
                in_req = 0;
                mem.memoryWriteComplete = spur;
            end
        end
    end

    // Queue the model's writes (at most maxw) then pulse start for one cycle
    task automatic launch(input int x, input int y, input int w, input int h,
                          input int c, input int a, input int maxw);
        int n = 0;
        int xe = (x + w < 320) ? x + w : 320;
        int ye = (y + h < 240) ? y + h : 240;
        for (int yy = y; yy < ye; yy++)
            for (int xx = x; xx < xe; xx++) begin
                int d = c;
`ifdef RECT_FILL_PATTERN_EN
                if (((xx ^ yy) & 1) != 0) d = a;
`endif
                if (n < maxw) sb.push_back({9'(xx), 8'(yy), 8'(d)});
                n++;
            end
        @(negedge clock);
        rectX = 9'(x); rectY = 8'(y); rectWidth = 9'(w); rectHeight = 8'(h);
        fillColor = 8'(c); fillColorAlt = 8'(a);
        first_pend = 1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (done_cnt == d0 && t < 3000) begin @(negedge clock); t++; end
        chk("done_seen", 32'(done_cnt != d0), 32'd1);
        @(negedge clock);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_wr(input int target);
        int t = 0;
        while (wr_cnt < target && t < 3000) begin @(negedge clock); t++; end
        chk("wr_reached", 32'(wr_cnt >= target), 32'd1);
    endtask

    initial begin
        int d0, w0;
        repeat (3) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(mem.memoryWriteRequest), 32'd0);
        chk("rst_x", 32'(mem.memoryXCoord), 32'd0);
        chk("rst_y", 32'(mem.memoryYCoord), 32'd0);
        chk("rst_data", 32'(mem.memoryWriteData), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Basic 2x2 fill, complete one cycle after each request
        ack_delay = 0; d0 = done_cnt; w0 = wr_cnt;
        launch(10, 5, 2, 2, 8'h3C, 0, 99);
        wait_done(d0);
        chk("basic_wr", 32'(wr_cnt - w0), 32'd4);
        chk("first_req_lat", 32'(first_req_cyc - start_cyc), 32'd2);
        chk("basic_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Empty rectangles: zero width, then origin off-screen
        d0 = done_cnt; w0 = wr_cnt;
        launch(10, 5, 0, 3, 8'h55, 0, 99);
        wait_done(d0);
        chk("empty_w_wr", 32'(wr_cnt - w0), 32'd0);
        chk("empty_w_lat", 32'(done_cyc - start_cyc), 32'd2);
        d0 = done_cnt; w0 = wr_cnt;
        launch(330, 5, 4, 3, 8'h55, 0, 99);
        wait_done(d0);
        chk("empty_x_wr", 32'(wr_cnt - w0), 32'd0);
        chk("empty_x_lat", 32'(done_cyc - start_cyc), 32'd2);

        // Clip at the bottom-right corner
        d0 = done_cnt; w0 = wr_cnt;
        launch(318, 238, 4, 4, 8'hA5, 0, 99);
        wait_done(d0);
        chk("clip_wr", 32'(wr_cnt - w0), 32'd4);

        // Slow acknowledge, with a second start mid-fill that must be ignored
        ack_delay = 5; d0 = done_cnt; w0 = wr_cnt;
        launch(100, 50, 2, 2, 8'h5A, 0, 99);
        repeat (8) @(negedge clock);
        rectX = 9'd0; rectY = 8'd0; rectWidth = 9'd8; rectHeight = 8'd8;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(d0);
        chk("slow_wr", 32'(wr_cnt - w0), 32'd4);
        repeat (10) @(negedge clock);
        chk("slow_no_restart", 32'(wr_cnt - w0), 32'd4);
        chk("slow_idle_busy", 32'(busy), 32'd0);

        // Abort during the 3rd write of a 10x1 fill
        ack_delay = 2; d0 = done_cnt; w0 = wr_cnt;
        launch(0, 0, 10, 1, 8'h77, 0, 3);
        wait_wr(w0 + 3);
        abort = 1'b1;
        wait_done(d0);
        abort = 1'b0;
        chk("abort_wr", 32'(wr_cnt - w0), 32'd3);

        // Abort while in SETUP: no writes at all
        ack_delay = 0; d0 = done_cnt; w0 = wr_cnt;
        launch(40, 40, 3, 3, 8'h99, 0, 0);
        abort = 1'b1;
        wait_done(d0);
        abort = 1'b0;
        chk("abort_setup_wr", 32'(wr_cnt - w0), 32'd0);

        // Abort and stray completes while idle have no effect
        d0 = done_cnt; w0 = wr_cnt;
        abort = 1'b1; spur = 1;
        repeat (5) @(negedge clock);
        abort = 1'b0; spur = 0;
        @(negedge clock);
        chk("idle_abort_busy", 32'(busy), 32'd0);
        chk("idle_abort_done", 32'(done_cnt - d0), 32'd0);
        launch(7, 9, 3, 1, 8'hC3, 0, 99);
        wait_done(d0);
        chk("post_idle_wr", 32'(wr_cnt - w0), 32'd3);

        // Reset while a write is waiting
        ack_delay = 4; d0 = done_cnt; w0 = wr_cnt;
        launch(20, 20, 4, 1, 8'h66, 0, 99);
        wait_wr(w0 + 1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #2;
        chk("midrst_req", 32'(mem.memoryWriteRequest), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_x", 32'(mem.memoryXCoord), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        repeat (10) @(negedge clock);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);

`ifdef RECT_FILL_PATTERN_EN
        // Checkerboard colours on a 2x1 strip at the origin
        ack_delay = 0; d0 = done_cnt; w0 = wr_cnt;
        launch(0, 0, 2, 1, 8'h11, 8'h22, 99);
        wait_done(d0);
        chk("pattern_wr", 32'(wr_cnt - w0), 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
